// File: rtl/mux16_pkg.sv
// Shared types and helpers for the 16-source round-robin mux scheduler.
package mux16_pkg;

    localparam int N_SRC = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic logic [N_SRC-1:0] onehot16(
        input logic [SEL_W-1:0] idx
    );
        logic [N_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux16_rr_sched_if.sv
// Source/consumer bundle of the scheduler: requests, data bits,
// downstream handshake and grant status.
interface mux16_rr_sched_if;
    import mux16_pkg::*;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] a;
    logic             out_ready;
    logic             y;
    logic             y_valid;
    logic [SEL_W-1:0] sel;
    logic [N_SRC-1:0] gnt;
    logic             busy;

    modport master (
        output req, a, out_ready,
        input  y, y_valid, sel, gnt, busy
    );

    modport slave (
        input  req, a, out_ready,
        output y, y_valid, sel, gnt, busy
    );

endinterface

// File: rtl/mux16.sv
// Plain 16:1 single-bit mux.
module mux16 (
    input  logic [15:0] d,
    input  logic [3:0]  s,
    output logic        y
);

    assign y = d[s];

endmodule

// File: rtl/rr_pick16.sv
// Round-robin picker: first requester after ptr, wrapping,
// with ptr itself searched last.
module rr_pick16
    import mux16_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick = ptr;
        idx  = '0;
        any  = |req;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) pick = idx;
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing one 16:1 bit mux among 16
// requesters with bounded bursts per grant.
module mux16_rr_sched
    import mux16_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mux16_rr_sched_if.slave   bus
);

    localparam int CNT_W =
        (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(BURST_LEN - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0] pick;
    logic             any;
    logic             yv;
    logic             xfer;
    logic             rel;

    rr_pick16 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick),
        .any  (any)
    );

    mux16 u_mux (
        .d (bus.a),
        .s (sel_q),
        .y (bus.y)
    );

    assign yv   = (state_q == BUSY) & bus.req[sel_q];
    assign xfer = yv & bus.out_ready;
    // Burst end and requester drop collapse into one release.
    assign rel  = ~bus.req[sel_q] |
                  (xfer & (cnt_q == CNT_MAX));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = BUSY;
                    sel_d   = pick;
                    ptr_d   = pick;
                    gnt_d   = onehot16(pick);
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (rel) begin
                    cnt_d = '0;
                    if (any) begin
                        sel_d = pick;
                        ptr_d = pick;
                        gnt_d = onehot16(pick);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N_SRC - 1);
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.y_valid = yv;
    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == BUSY);

endmodule
